// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - request/response bundle for the sequential ALU
interface alu_seq_param_if #(
  parameter int WIDTH     = 8,
  parameter int IMM_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [IMM_WIDTH-1:0] imm;
  logic                 use_imm;
  logic [3:0]           alu_op;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [WIDTH-1:0]     result_hi;
  logic                 carry_out;
  logic                 zero;
  logic                 overflow;
  logic                 underflow;
  logic                 div_zero;
  logic                 busy;

  modport master (
    output in_valid, a, b, imm, use_imm, alu_op, out_ready,
    input  in_ready, out_valid, result, result_hi, carry_out, zero,
           overflow, underflow, div_zero, busy
  );

  modport slave (
    input  in_valid, a, b, imm, use_imm, alu_op, out_ready,
    output in_ready, out_valid, result, result_hi, carry_out, zero,
           overflow, underflow, div_zero, busy
  );
endinterface

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - handshaked ALU with iterative multiply and divide
module alu_seq_param #(
  parameter int WIDTH     = 8,
  parameter int IMM_WIDTH = 4
) (
  input logic             clk,
  input logic             reset,
  alu_seq_param_if.slave  io
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // hi/lo hold partial product + multiplier for MUL, remainder + quotient for DIV/MOD
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   b_eff;
  logic               op_is_iter;
  logic [WIDTH:0]     add_sum;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   res_c;

  // next-state, datapath step and registered-output computation
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    dz_d        = dz_q;
    res_c       = '0;

    b_eff      = io.use_imm ? WIDTH'(io.imm) : io.b;
    op_is_iter = (io.alu_op == OP_MUL) || (io.alu_op == OP_DIV) || (io.alu_op == OP_MOD);
    add_sum    = {1'b0, a_q} + {1'b0, b_q};
    shamt      = b_q[SH_W-1:0];
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_r      = {hi_q, lo_q[WIDTH-1]};
    div_ge     = div_r >= {1'b0, b_q};
    div_sub    = WIDTH'(div_r - {1'b0, b_q});

    case (state_q)
      S_IDLE: begin
        if (io.in_valid && in_ready_q) begin
          op_d    = io.alu_op;
          a_d     = io.a;
          b_d     = b_eff;
          hi_d    = '0;
          lo_d    = (io.alu_op == OP_MUL) ? b_eff : io.a;
          cnt_d   = '0;
          state_d = op_is_iter ? S_ITER : S_EXEC;
        end
      end
      S_EXEC: begin
        carry_d     = 1'b0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        dz_d        = 1'b0;
        result_hi_d = '0;
        case (op_q)
          OP_ADD: begin
            res_c   = add_sum[WIDTH-1:0];
            carry_d = add_sum[WIDTH];
            ovf_d   = add_sum[WIDTH];
          end
          OP_SUB: begin
            res_c = a_q - b_q;
            unf_d = a_q < b_q;
          end
          OP_AND:  res_c = a_q & b_q;
          OP_OR:   res_c = a_q | b_q;
          OP_XOR:  res_c = a_q ^ b_q;
          OP_NOT:  res_c = ~a_q;
          OP_SHL:  res_c = a_q << shamt;
          OP_SHR:  res_c = a_q >> shamt;
          default: res_c = '0;
        endcase
        result_d = res_c;
        zero_d   = (res_c == '0);
        state_d  = S_DONE;
      end
      S_ITER: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          // all bits processed: publish product or quotient/remainder
          res_c       = (op_q == OP_MOD) ? hi_q : lo_q;
          result_d    = res_c;
          result_hi_d = hi_q;
          zero_d      = (res_c == '0);
          carry_d     = 1'b0;
          unf_d       = 1'b0;
          ovf_d       = (op_q == OP_MUL) && (|hi_q);
          dz_d        = (op_q != OP_MUL) && (b_q == '0);
          state_d     = S_DONE;
        end else begin
          if (op_q == OP_MUL) begin
            {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
          end else begin
            // a zero divisor always subtracts, giving all-ones quotient and remainder A
            hi_d = div_ge ? div_sub : div_r[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_valid_q && io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // state and output registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      dz_q        <= dz_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.busy      = busy_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.result_hi = result_hi_q;
  assign io.carry_out = carry_q;
  assign io.zero      = zero_q;
  assign io.overflow  = ovf_q;
  assign io.underflow = unf_q;
  assign io.div_zero  = dz_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - randomized and directed checks of alu_seq_param against an arithmetic model
module tb_alu_seq_param;
  localparam int W    = 8;
  localparam int MASK = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  alu_seq_param_if #(.WIDTH(8), .IMM_WIDTH(4)) bus ();

  alu_seq_param #(.WIDTH(8), .IMM_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output int res, output int hi, output int c, output int z,
                                output int o, output int u, output int dz, output int lat);
    int s;
    res = 0; hi = 0; c = 0; o = 0; u = 0; dz = 0; lat = 2;
    case (op)
      0: begin s = a + b; res = s % 256; c = s / 256; o = c; end
      1: begin res = (a - b + 256) % 256; u = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = MASK - a;
      6: res = (a << (b % W)) & MASK;
      7: res = a >> (b % W);
      8: begin s = a * b; res = s % 256; hi = s / 256; o = (hi != 0) ? 1 : 0; lat = W + 2; end
      9: begin
        lat = W + 2;
        if (b == 0) begin res = MASK; hi = a; dz = 1; end
        else begin res = a / b; hi = a % b; end
      end
      10: begin
        lat = W + 2;
        if (b == 0) begin res = a; hi = a; dz = 1; end
        else begin res = a % b; hi = a % b; end
      end
      default: res = 0;
    endcase
    z = (res == 0) ? 1 : 0;
  endfunction

  task automatic run_op(input int op, input int av, input int bv, input int immv,
                        input bit ui, input int hold, input bit poke);
    int er, eh, ec, ez, eo, eu, ed, el, lat, bb;
    bb = ui ? immv : bv;
    model(op, av, bb, er, eh, ec, ez, eo, eu, ed, el);
    @(negedge clk);
    for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'(op);
    bus.a        = 8'(av);
    bus.b        = 8'(bv);
    bus.imm      = 4'(immv);
    bus.use_imm  = ui;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.imm      = 4'($urandom);
    bus.use_imm  = 1'($urandom);
    bus.alu_op   = 4'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("result", int'(bus.result), er);
    chk("result_hi", int'(bus.result_hi), eh);
    chk("carry_out", int'(bus.carry_out), ec);
    chk("zero", int'(bus.zero), ez);
    chk("overflow", int'(bus.overflow), eo);
    chk("underflow", int'(bus.underflow), eu);
    chk("div_zero", int'(bus.div_zero), ed);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.alu_op   = 4'd0;
      end
      @(posedge clk); #1;
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_result", int'(bus.result), er);
      chk("hold_result_hi", int'(bus.result_hi), eh);
      chk("hold_flags", int'({bus.carry_out, bus.zero, bus.overflow, bus.underflow, bus.div_zero}),
          (ec << 4) | (ez << 3) | (eo << 2) | (eu << 1) | ed);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op, av, bv, immv;
    bit ui;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.imm       = '0;
    bus.use_imm   = 1'b0;
    bus.alu_op    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_result", int'(bus.result), 0);
    reset = 1'b0;

    run_op(0, 200, 100, 0, 1'b0, 0, 1'b0);
    run_op(1, 5, 7, 0, 1'b0, 0, 1'b0);
    run_op(1, 9, 200, 9, 1'b1, 0, 1'b0);
    run_op(8, 16, 20, 0, 1'b0, 0, 1'b0);
    run_op(9, 100, 7, 0, 1'b0, 0, 1'b0);
    run_op(10, 100, 7, 0, 1'b0, 0, 1'b0);
    run_op(9, 100, 0, 0, 1'b0, 0, 1'b0);
    run_op(10, 100, 0, 0, 1'b0, 0, 1'b0);
    run_op(8, 255, 255, 0, 1'b0, 0, 1'b0);
    run_op(13, 77, 3, 0, 1'b0, 0, 1'b0);
    run_op(3, 18, 52, 0, 1'b0, 5, 1'b1);

    // reset during the fourth cycle of a multiply
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'd8;
    bus.a        = 8'd16;
    bus.b        = 8'd20;
    bus.use_imm  = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_result_hi", int'(bus.result_hi), 0);
    chk("abort_flags", int'({bus.carry_out, bus.zero, bus.overflow, bus.underflow, bus.div_zero}), 0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_result", int'(bus.out_valid), 0);
    run_op(6, 'h81, 0, 3, 1'b1, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op   = int'($urandom_range(0, 15));
      av   = int'($urandom_range(0, 255));
      bv   = int'($urandom_range(0, 255));
      immv = int'($urandom_range(0, 15));
      ui   = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bv = 0;
        ui = 1'b0;
      end
      run_op(op, av, bv, immv, ui, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
